usr_cmd_sequencer: RTL and testbench

USR_CMD_SEQUENCER -- requirements
Module: usr_cmd_sequencer

---
 rtl/usr_pkg.sv | 24 ++
 rtl/usr_cmd_fifo.sv | 71 +++++++
 rtl/usr_cmd_sequencer.sv | 143 ++++++++++++++
 tb/tb_usr_cmd_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the command sequencer that drives a downstream
// universal shift register: op codes, FSM state type, queue defaults.
package usr_pkg;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_RIGHT = 3'b001;
    localparam logic [2:0] OP_LEFT  = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_INV   = 3'b100;

    localparam int DEPTH_DEFAULT = 4;
    localparam int CMD_W         = 10;   // {op[2:0], cnt[2:0], data[3:0]}

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Ops above OP_INV have no meaning downstream.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_INV);
    endfunction

endpackage

// File: rtl/usr_cmd_fifo.sv
// Command queue for the sequencer.
// Ports:
//   clk, clear      clock, asynchronous active-low reset (queue empty)
//   push_i/wdata_i  write one entry (ignored when full)
//   pop_i           drop head entry (ignored when empty)
//   rdata_o         head entry, valid while !empty_o
//   full_o/empty_o  occupancy flags, from registered count only
module usr_cmd_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only read while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer: queues {op, cnt, data} commands and issues each one to
// a downstream universal shift register for cnt+1 consecutive cycles.
// Ports:
//   clk, clear                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready = queue not full)
//   cmd_op/cmd_cnt/cmd_data    op code, repeat count minus one, load data
//   S, I                       registered op select / data to downstream
//   busy                       a command is being issued
//   done                       pulse on the last issue cycle of a command
//   err                        pulse the cycle after an illegal op is taken
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | nothing issuing, S=000, waiting for a queued command
// ST_RUN  | issuing current command, cnt_q cycles remain after this one
module usr_cmd_sequencer
    import usr_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_cnt,
    input  logic [3:0] cmd_data,
    output logic [2:0] S,
    output logic [3:0] I,
    output logic       busy,
    output logic       done,
    output logic       err
);

    seq_state_e       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       s_q, s_d;
    logic [3:0]       i_q, i_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept, legal, push, pop;
    logic             fifo_full, fifo_empty;
    logic [CMD_W-1:0] head;
    logic [2:0]       head_op, head_cnt;
    logic [3:0]       head_data;

    assign cmd_ready = ~fifo_full;
    assign accept    = cmd_valid & cmd_ready;
    assign legal     = op_legal(cmd_op);
    assign push      = accept & legal;

    assign {head_op, head_cnt, head_data} = head;

    usr_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clear   (clear),
        .push_i  (push),
        .wdata_i ({cmd_op, cmd_cnt, cmd_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        i_d     = i_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = accept & ~legal;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pop = ~fifo_empty;
            end
            ST_RUN: begin
                if (cnt_q == 3'd0) begin
                    // Last cycle: chain straight into the next command if any.
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        s_d     = OP_HOLD;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_q - 3'd1;
                    done_d = (cnt_q == 3'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = OP_HOLD;
                busy_d  = 1'b0;
            end
        endcase

        // done is registered, so it is raised when entering the final cycle.
        if (pop) begin
            state_d = ST_RUN;
            s_d     = head_op;
            i_d     = head_data;
            cnt_d   = head_cnt;
            busy_d  = 1'b1;
            done_d  = (head_cnt == 3'd0);
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            s_q     <= OP_HOLD;
            i_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign S    = s_q;
    assign I    = i_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
module tb_usr_cmd_sequencer;
    import usr_pkg::*;

    logic       clk = 1'b0;
    logic       clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic [2:0] S;
    logic [3:0] I;
    logic       busy, done, err;

    usr_cmd_sequencer #(.DEPTH(4)) dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .S         (S),
        .I         (I),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] s;
        logic [3:0] i;
        logic       d;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         err_cyc  = -1;
    logic [3:0] last_i   = 4'd0;
    logic       prev_busy = 1'b0;
    int         busy_cycles, done_pulses, segments;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every busy cycle must match the next scoreboard entry.
    always @(negedge clk) begin
        if (clear) begin
            check("err", err, (cyc == err_cyc));
            if (busy) begin
                busy_cycles++;
                if (!prev_busy) segments++;
                if (done) done_pulses++;
                if (sb.size() == 0) begin
                    check("busy_unexpected", busy, 0);
                end else begin
                    e = sb.pop_front();
                    check("S", S, e.s);
                    check("I", I, e.i);
                    check("done", done, e.d);
                    last_i = e.i;
                end
            end else begin
                check("S_idle", S, OP_HOLD);
                check("I_hold", I, last_i);
                check("done_idle", done, 0);
            end
            prev_busy = busy;
        end
    end

    task automatic clr_stats();
        busy_cycles = 0;
        done_pulses = 0;
        segments    = 0;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data);
        int g = 0;
        int c = cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        while (!cmd_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) begin
            check("send_ready", cmd_ready, 1);
        end else if (op_legal(op)) begin
            for (int k = 0; k <= c; k++)
                sb.push_back('{s: op, i: data, d: (k == c)});
        end else begin
            err_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        repeat (2) @(negedge clk);
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("drain", busy, 0);
        check("sb_empty", sb.size(), 0);
    endtask

    // One command into an idle block: latency and run length.
    task automatic run_single(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data);
        int c = cnt;
        clr_stats();
        send(op, cnt, data);
        @(negedge clk);
        check("latency_pre", busy, 0);
        @(negedge clk);
        check("latency_first", busy, 1);
        wait_idle();
        check("run_len", busy_cycles, c + 1);
        check("run_done", done_pulses, 1);
        check("run_seg", segments, 1);
    endtask

    initial begin
        int  g;
        logic pd;
        clear     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_cnt   = 3'd0;
        cmd_data  = 4'd0;
        #1;
        check("rst_S", S, 0);
        check("rst_I", I, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", cmd_ready, 1);
        repeat (3) @(negedge clk);
        #2 clear = 1'b1;

        // single right shift, cnt=2
        run_single(OP_RIGHT, 3'd2, 4'($urandom_range(0, 15)));

        // back-to-back load then left shift
        clr_stats();
        send(OP_LOAD, 3'd0, 4'b1010);
        send(OP_LEFT, 3'd1, 4'b0110);
        wait_idle();
        check("b2b_cycles", busy_cycles, 3);
        check("b2b_done", done_pulses, 2);
        check("b2b_seg", segments, 1);

        // fill queue behind a long command, illegal op in between
        clr_stats();
        send(OP_RIGHT, 3'd7, 4'h1);
        send(OP_LEFT,  3'd7, 4'h2);
        send(OP_LOAD,  3'd7, 4'h3);
        send(OP_INV,   3'd7, 4'h4);
        send(3'b110,   3'd5, 4'hF);
        @(negedge clk);
        check("ready_after_illegal", cmd_ready, 1);
        send(OP_HOLD,  3'd7, 4'h5);
        @(negedge clk);
        check("ready_full", cmd_ready, 0);
        g  = 0;
        pd = done;
        while (!cmd_ready && g < 100) begin
            pd = done;
            @(negedge clk);
            g++;
        end
        check("ready_return", cmd_ready, 1);
        check("ready_after_pop", pd, 1);
        wait_idle();
        check("full_cycles", busy_cycles, 40);
        check("full_done", done_pulses, 4 + 1);
        check("full_seg", segments, 1);

        // reset mid-run with two commands queued
        send(OP_RIGHT, 3'd7, 4'h5);
        send(OP_LEFT,  3'd3, 4'h6);
        send(OP_LOAD,  3'd2, 4'h9);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        @(posedge clk);
        #2 clear = 1'b0;
        #1;
        check("mrst_S", S, 0);
        check("mrst_I", I, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_ready", cmd_ready, 1);
        sb.delete();
        last_i    = 4'd0;
        err_cyc   = -1;
        prev_busy = 1'b0;
        repeat (2) @(negedge clk);
        #2 clear = 1'b1;
        clr_stats();
        repeat (12) @(negedge clk);
        check("post_rst_busy", busy_cycles, 0);
        check("post_rst_done", done_pulses, 0);

        // repeat-count boundaries
        run_single(OP_HOLD, 3'd0, 4'hC);
        run_single(OP_INV,  3'd7, 4'h3);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
